// File: rtl/digit_set_controller_pkg.sv
// Shared definitions for the front-panel digit/ID controller: state encodings,
// default per-digit limits, button bit positions and the digit-index width helper.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_SET    = 4'd1,
        ST_LOAD   = 4'd2,
        ST_RUN    = 4'd3,
        ST_IDLE   = 4'd4,
        ST_PAUSED = 4'd5
    } ctrlState_t;

    localparam logic [23:0] DIGIT_MAX_DEFAULT = 24'h125959;

    localparam int BTN_LOAD  = 0;
    localparam int BTN_SET   = 1;
    localparam int BTN_START = 2;
    localparam int BTN_STOP  = 3;

    function automatic int idxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_set_controller_if.sv
// Panel bus between the board switches/buttons and the controller, and from the
// controller to timer/display/ROM. The panel side is master, the controller slave.
interface digit_set_controller_if
    import ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DIGIT_W    = 4,
    parameter int ID_W       = 8
) ();
    localparam int IDX_W = idxWidth(NUM_DIGITS);

    logic                          setBtn;
    logic                          loadBtn;
    logic                          startBtn;
    logic                          stopBtn;
    logic [DIGIT_W-1:0]            digitSw;
    logic [ID_W-1:0]               idSw;
    logic [NUM_DIGITS*DIGIT_W-1:0] timeDigits;
    logic [IDX_W-1:0]              digitIndex;
    logic [ID_W-1:0]               patientId;
    logic                          loadStrobe;
    logic                          setDone;
    logic                          runEnable;
    logic [3:0]                    state;

    modport master (
        output setBtn, loadBtn, startBtn, stopBtn, digitSw, idSw,
        input  timeDigits, digitIndex, patientId, loadStrobe, setDone, runEnable, state
    );

    modport slave (
        input  setBtn, loadBtn, startBtn, stopBtn, digitSw, idSw,
        output timeDigits, digitIndex, patientId, loadStrobe, setDone, runEnable, state
    );

endinterface

// File: rtl/digit_set_controller_btn_debounce.sv
// Single-bit button debouncer: the output level follows the input only after
// DEBOUNCE_CY consecutive samples that disagree with the current output.
module btn_debounce #(
    parameter int DEBOUNCE_CY = 16
) (
    input  logic clk,
    input  logic resetN,
    input  logic btnIn,
    output logic btnOut
);
    localparam int CNT_W = $clog2(DEBOUNCE_CY + 1);

    logic             sampleR;
    logic [CNT_W-1:0] cntR;

    // Sample the pin, count disagreeing samples, flip the level once stable.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            sampleR <= 1'b0;
            cntR    <= {CNT_W{1'b0}};
            btnOut  <= 1'b0;
        end else begin
            sampleR <= btnIn;
            if (sampleR == btnOut) begin
                cntR <= {CNT_W{1'b0}};
            end else if (cntR == CNT_W'(DEBOUNCE_CY - 1)) begin
                btnOut <= sampleR;
                cntR   <= {CNT_W{1'b0}};
            end else begin
                cntR <= cntR + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/digit_set_controller.sv
// Front-panel controller: edge-detected buttons, stop>start>set>load priority, BCD
// digit entry with per-digit limits, patient-ID latch. Define CTRL_DEBOUNCE_EN to debounce buttons.
module digit_set_controller
    import ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DIGIT_W    = 4,
    parameter int ID_W       = 8,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DIGIT_MAX = DIGIT_MAX_DEFAULT
`ifdef CTRL_DEBOUNCE_EN
    , parameter int DEBOUNCE_CY = 16
`endif
) (
    input  logic                   clk,
    input  logic                   resetN,
    digit_set_controller_if.slave  panel
);
    localparam int IDX_W = idxWidth(NUM_DIGITS);
    localparam int TW    = NUM_DIGITS * DIGIT_W;

    logic [3:0]         btnRaw;
    logic [3:0]         btnR;
    logic [3:0]         btnPrevR;
    logic [3:0]         edgeR;
    logic [DIGIT_W-1:0] digitSwR;
    logic [ID_W-1:0]    idSwR;

    ctrlState_t         stateR, nextState, holdState;
    logic [TW-1:0]      digitsR, nextDigits;
    logic [IDX_W-1:0]   idxR, nextIdx;
    logic [ID_W-1:0]    idR, nextId;
    logic               strobeR, nextStrobe;
    logic               doneR, nextDone;
    logic               runEnR;
    logic               canSet, canLoad;

    assign btnRaw = {panel.stopBtn, panel.startBtn, panel.setBtn, panel.loadBtn};

    function automatic logic [DIGIT_W-1:0] digitLimit(input logic [IDX_W-1:0] idx);
        return DIGIT_MAX[(NUM_DIGITS - 1 - int'(idx)) * DIGIT_W +: DIGIT_W];
    endfunction

`ifdef CTRL_DEBOUNCE_EN
    for (genvar b = 0; b < 4; b++) begin : gDeb
        btn_debounce #(.DEBOUNCE_CY(DEBOUNCE_CY)) uDeb (
            .clk    (clk),
            .resetN (resetN),
            .btnIn  (btnRaw[b]),
            .btnOut (btnR[b])
        );
    end
`else
    // Single register stage on the raw button levels.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            btnR <= 4'b0000;
        end else begin
            btnR <= btnRaw;
        end
    end
`endif

    // Rising-edge detection (registered) and switch sampling.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            btnPrevR <= 4'b0000;
            edgeR    <= 4'b0000;
            digitSwR <= {DIGIT_W{1'b0}};
            idSwR    <= {ID_W{1'b0}};
        end else begin
            btnPrevR <= btnR;
            edgeR    <= btnR & ~btnPrevR;
            digitSwR <= panel.digitSw;
            idSwR    <= panel.idSw;
        end
    end

    // Prioritised action decode; only the highest pending edge is considered.
    always_comb begin
        case (stateR)
            ST_RESET, ST_SET, ST_LOAD: holdState = ST_IDLE;
            default:                   holdState = stateR;
        endcase
        canSet     = (stateR == ST_IDLE) || (stateR == ST_PAUSED) || (stateR == ST_SET);
        canLoad    = canSet || (stateR == ST_LOAD);
        nextState  = holdState;
        nextDigits = digitsR;
        nextIdx    = idxR;
        nextId     = idR;
        nextStrobe = 1'b0;
        nextDone   = 1'b0;
        if (edgeR[BTN_STOP]) begin
            nextState = (stateR == ST_RUN) ? ST_PAUSED : holdState;
        end else if (edgeR[BTN_START]) begin
            if (stateR != ST_RUN) begin
                nextState = ST_RUN;
                nextIdx   = {IDX_W{1'b0}};
            end else begin
                nextState = holdState;
            end
        end else if (edgeR[BTN_SET] && canSet) begin
            nextDigits[(NUM_DIGITS - 1 - int'(idxR)) * DIGIT_W +: DIGIT_W] =
                (digitSwR > digitLimit(idxR)) ? digitLimit(idxR) : digitSwR;
            nextState = ST_SET;
            if (idxR == IDX_W'(NUM_DIGITS - 1)) begin
                nextIdx  = {IDX_W{1'b0}};
                nextDone = 1'b1;
            end else begin
                nextIdx = idxR + IDX_W'(1);
            end
        end else if (edgeR[BTN_LOAD] && canLoad) begin
            nextId     = idSwR;
            nextStrobe = 1'b1;
            nextState  = ST_LOAD;
        end else begin
            nextState = holdState;
        end
    end

    // State and datapath registers; every panel output comes straight from here.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            stateR  <= ST_RESET;
            digitsR <= {TW{1'b0}};
            idxR    <= {IDX_W{1'b0}};
            idR     <= {ID_W{1'b0}};
            strobeR <= 1'b0;
            doneR   <= 1'b0;
            runEnR  <= 1'b0;
        end else begin
            stateR  <= nextState;
            digitsR <= nextDigits;
            idxR    <= nextIdx;
            idR     <= nextId;
            strobeR <= nextStrobe;
            doneR   <= nextDone;
            runEnR  <= (nextState == ST_RUN);
        end
    end

    assign panel.timeDigits = digitsR;
    assign panel.digitIndex = idxR;
    assign panel.patientId  = idR;
    assign panel.loadStrobe = strobeR;
    assign panel.setDone    = doneR;
    assign panel.runEnable  = runEnR;
    assign panel.state      = stateR;

endmodule

// File: tb/tb_digit_set_controller.sv
// Directed bench for digit_set_controller: hand-computed expectations checked
// with immediate assertions one clock step after each action lands.
module tb_digit_set_controller;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;

    digit_set_controller_if #(.NUM_DIGITS(6), .DIGIT_W(4), .ID_W(8)) ifc ();

    digit_set_controller dut (
        .clk    (clk),
        .resetN (resetN),
        .panel  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse the selected buttons for one sample; returns when the action is visible.
    task automatic press(input logic sp, input logic st, input logic se, input logic ld);
        ifc.stopBtn  = sp;
        ifc.startBtn = st;
        ifc.setBtn   = se;
        ifc.loadBtn  = ld;
        step(1);
        ifc.stopBtn  = 1'b0;
        ifc.startBtn = 1'b0;
        ifc.setBtn   = 1'b0;
        ifc.loadBtn  = 1'b0;
        step(2);
    endtask

    logic [3:0] swVals [6];
    logic [2:0] expIdx;

    initial begin
        checks = 0;
        errors = 0;
        swVals = '{4'h1, 4'h9, 4'h7, 4'h3, 4'h8, 4'hF};
        resetN       = 1'b0;
        ifc.setBtn   = 1'b0;
        ifc.loadBtn  = 1'b0;
        ifc.startBtn = 1'b0;
        ifc.stopBtn  = 1'b0;
        ifc.digitSw  = 4'h0;
        ifc.idSw     = 8'h00;

        // Reset
        step(2);
        check("rst_time",   64'(ifc.timeDigits), 64'h0);
        check("rst_idx",    64'(ifc.digitIndex), 64'h0);
        check("rst_id",     64'(ifc.patientId),  64'h0);
        check("rst_strobe", 64'(ifc.loadStrobe), 64'h0);
        check("rst_done",   64'(ifc.setDone),    64'h0);
        check("rst_run",    64'(ifc.runEnable),  64'h0);
        check("rst_state",  64'(ifc.state),      64'h0);
        resetN = 1'b1;
        step(1);
        check("post_rst_state", 64'(ifc.state), 64'h4);

        // Six digit entries with clamping against 1,2,5,9,5,9
        for (int i = 0; i < 6; i++) begin
            ifc.digitSw = swVals[i];
            press(1'b0, 1'b0, 1'b1, 1'b0);
            expIdx = (i == 5) ? 3'd0 : 3'(i + 1);
            check("set_idx",   64'(ifc.digitIndex), 64'(expIdx));
            check("set_done",  64'(ifc.setDone),    (i == 5) ? 64'h1 : 64'h0);
            check("set_state", 64'(ifc.state),      64'h1);
        end
        check("set_time", 64'(ifc.timeDigits), 64'h125359);
        step(1);
        check("set_done_clr", 64'(ifc.setDone), 64'h0);
        check("set_idle",     64'(ifc.state),   64'h4);

        // Load patient ID
        ifc.idSw = 8'hA5;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check("load_id",     64'(ifc.patientId),  64'hA5);
        check("load_strobe", 64'(ifc.loadStrobe), 64'h1);
        check("load_state",  64'(ifc.state),      64'h2);
        step(1);
        check("load_strobe_clr", 64'(ifc.loadStrobe), 64'h0);
        check("load_idle",       64'(ifc.state),      64'h4);

        // Run: set/load ignored, stop pauses, start resumes
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check("run_state", 64'(ifc.state),     64'h3);
        check("run_en",    64'(ifc.runEnable), 64'h1);
        ifc.digitSw = 4'h5;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("run_set_ign", 64'(ifc.timeDigits), 64'h125359);
        check("run_set_idx", 64'(ifc.digitIndex), 64'h0);
        ifc.idSw = 8'h3C;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check("run_load_ign", 64'(ifc.patientId), 64'hA5);
        check("run_hold",     64'(ifc.state),     64'h3);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("stop_state", 64'(ifc.state),     64'h5);
        check("stop_run",   64'(ifc.runEnable), 64'h0);
        step(2);
        check("paused_hold", 64'(ifc.state), 64'h5);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check("resume_state", 64'(ifc.state),     64'h3);
        check("resume_run",   64'(ifc.runEnable), 64'h1);

        // Start and set in the same cycle: start wins, no digit written
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("stop2_state", 64'(ifc.state), 64'h5);
        ifc.digitSw = 4'h7;
        press(1'b0, 1'b1, 1'b1, 1'b0);
        check("prio_state", 64'(ifc.state),      64'h3);
        check("prio_idx",   64'(ifc.digitIndex), 64'h0);
        check("prio_time",  64'(ifc.timeDigits), 64'h125359);

        // Partial entry abandoned by reset
        press(1'b1, 1'b0, 1'b0, 1'b0);
        ifc.digitSw = 4'h0;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        ifc.digitSw = 4'h1;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("part_time", 64'(ifc.timeDigits), 64'h015359);
        check("part_idx",  64'(ifc.digitIndex), 64'h2);
        resetN = 1'b0;
        step(1);
        check("rst2_time",  64'(ifc.timeDigits), 64'h0);
        check("rst2_idx",   64'(ifc.digitIndex), 64'h0);
        check("rst2_state", 64'(ifc.state),      64'h0);
        resetN = 1'b1;
        step(1);
        check("rst2_idle", 64'(ifc.state), 64'h4);

        // Held button acts once
        ifc.digitSw = 4'h1;
        ifc.setBtn  = 1'b1;
        step(5);
        ifc.setBtn  = 1'b0;
        step(2);
        check("hold_idx",  64'(ifc.digitIndex), 64'h1);
        check("hold_time", 64'(ifc.timeDigits), 64'h100000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
